mmu_access_unit: RTL and testbench

- Parametrised successor to the MMU data path.
- Turns one CPU load/store request of byte/half/word/double size at any byte address into a sequence of full-word beats on the memory-controller (imc) interface:
  - read-modify-write for sub-word stores;
  - split beats for accesses that cross a word boundary;
  - sign or zero extension on loads.
- Sits between the core's memory stage and the memory controller.
- Scales to a 32- or 64-bit memory word.

---
 rtl/mmu_access_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mmu_access_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_access_unit.sv
// Turns one CPU load/store of byte..double size at any byte address into full-word imc beats.
// Optional feature macro: MMU_UNALIGNED_EN (split beats for word-crossing accesses).
module mmu_access_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic                  signed_read,
    input  logic [1:0]            data_width,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [XLEN-1:0]       data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [XLEN-1:0]       data_out,
    input  logic                  imc_mem_ready,
    input  logic [XLEN-1:0]       imc_data_out,
    output logic                  imc_read_enable,
    output logic                  imc_write_enable,
    output logic [ADDR_WIDTH-1:0] imc_address,
    output logic [XLEN-1:0]       imc_data_in
);
    localparam int unsigned W    = XLEN / 8;
    localparam int unsigned OFFW = $clog2(W);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdLo = 3'd1,
        StWrLo = 3'd2,
        StDone = 3'd3
`ifdef MMU_UNALIGNED_EN
        , StRdHi = 3'd4,
        StWrHi = 3'd5
`endif
    } state_e;

    state_e                state_q;
    logic                  req_write_q;
    logic                  req_signed_q;
    logic [1:0]            req_width_q;
    logic [OFFW-1:0]       req_off_q;
    logic [ADDR_WIDTH-1:0] req_lo_q;
    logic [XLEN-1:0]       req_data_q;
    logic [XLEN-1:0]       lo_buf_q;
`ifdef MMU_UNALIGNED_EN
    logic                  req_aligned_q;
    logic [XLEN-1:0]       hi_buf_q;
    logic [ADDR_WIDTH-1:0] hi_addr;
    logic [XLEN-1:0]       wr_hi_word;
`endif

    logic [OFFW-1:0]       acc_off;
    int unsigned           acc_bytes;
    logic                  acc_aligned;
    logic                  acc_fault;
    logic [ADDR_WIDTH-1:0] acc_lo;
    logic [2*XLEN-1:0]     load_pair;
    logic [XLEN-1:0]       load_result;
    logic [XLEN-1:0]       wr_lo_word;

    // Pick n bytes from {hi, lo} starting at byte off, then zero- or sign-extend.
    function automatic logic [XLEN-1:0] extract_load(input logic [2*XLEN-1:0] pair,
                                                     input logic [OFFW-1:0] off,
                                                     input logic [1:0] width,
                                                     input logic sgn);
        logic [2*XLEN-1:0] shifted;
        logic [XLEN-1:0]   result;
        logic              sign;
        int unsigned       nbytes;
        nbytes  = 32'd1 << width;
        shifted = pair >> {off, 3'b000};
        result  = '0;
        sign    = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i < nbytes) begin
                result[8*i +: 8] = shifted[8*i +: 8];
                sign             = shifted[8*i + 7];
            end else if (sgn && nbytes < W) begin
                result[8*i +: 8] = {8{sign}};
            end
        end
        return result;
    endfunction

    function automatic logic [XLEN-1:0] merge_lo(input logic [XLEN-1:0] word,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [1:0] width,
                                                 input logic [XLEN-1:0] data);
        logic [XLEN-1:0] result;
        int unsigned     nbytes;
        int unsigned     o;
        nbytes = 32'd1 << width;
        o      = 32'(off);
        result = word;
        for (int unsigned i = 0; i < W; i++) begin
            if (i >= o && i < o + nbytes) result[8*i +: 8] = data[8*(i-o) +: 8];
        end
        return result;
    endfunction

`ifdef MMU_UNALIGNED_EN
    // Bytes that spilled past the low word land at the bottom of the high word.
    function automatic logic [XLEN-1:0] merge_hi(input logic [XLEN-1:0] word,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [1:0] width,
                                                 input logic [XLEN-1:0] data);
        logic [XLEN-1:0] result;
        int unsigned     nbytes;
        int unsigned     o;
        nbytes = 32'd1 << width;
        o      = 32'(off);
        result = word;
        for (int unsigned i = 0; i < W; i++) begin
            if (i + W < o + nbytes) result[8*i +: 8] = data[8*(i+W-o) +: 8];
        end
        return result;
    endfunction
`endif

    always_comb begin
        acc_off     = address[OFFW-1:0];
        acc_bytes   = 32'd1 << data_width;
        acc_aligned = (32'(acc_off) + acc_bytes) <= W;
        acc_fault   = (XLEN == 32) && (data_width == 2'd3);
`ifndef MMU_UNALIGNED_EN
        if (!acc_aligned) acc_fault = 1'b1;
`endif
        acc_lo      = {address[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
`ifdef MMU_UNALIGNED_EN
        hi_addr     = req_lo_q + ADDR_WIDTH'(W);
        load_pair   = (state_q == StRdHi) ? {imc_data_out, lo_buf_q}
                                          : {{XLEN{1'b0}}, imc_data_out};
        wr_hi_word  = merge_hi(hi_buf_q, req_off_q, req_width_q, req_data_q);
`else
        load_pair   = {{XLEN{1'b0}}, imc_data_out};
`endif
        load_result = extract_load(load_pair, req_off_q, req_width_q, req_signed_q);
        wr_lo_word  = merge_lo((state_q == StRdLo) ? imc_data_out : lo_buf_q,
                               req_off_q, req_width_q, req_data_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
            data_out         <= '0;
            imc_read_enable  <= 1'b0;
            imc_write_enable <= 1'b0;
            imc_address      <= '0;
            imc_data_in      <= '0;
            req_write_q      <= 1'b0;
            req_signed_q     <= 1'b0;
            req_width_q      <= '0;
            req_off_q        <= '0;
            req_lo_q         <= '0;
            req_data_q       <= '0;
            lo_buf_q         <= '0;
`ifdef MMU_UNALIGNED_EN
            req_aligned_q    <= 1'b0;
            hi_buf_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (read_enable || write_enable) begin
                        busy         <= 1'b1;
                        data_out     <= '0;
                        req_write_q  <= write_enable;
                        req_signed_q <= signed_read;
                        req_width_q  <= data_width;
                        req_off_q    <= acc_off;
                        req_lo_q     <= acc_lo;
                        req_data_q   <= data_in;
`ifdef MMU_UNALIGNED_EN
                        req_aligned_q <= acc_aligned;
`endif
                        imc_address  <= acc_lo;
                        if (acc_fault) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            fault   <= 1'b1;
                        end else if (write_enable && acc_bytes == W) begin
                            state_q          <= StWrLo;
                            imc_write_enable <= 1'b1;
                            imc_data_in      <= data_in;
                        end else begin
                            state_q         <= StRdLo;
                            imc_read_enable <= 1'b1;
                        end
                    end
                end
                StRdLo: begin
                    if (imc_mem_ready) begin
                        lo_buf_q <= imc_data_out;
`ifdef MMU_UNALIGNED_EN
                        if (!req_aligned_q) begin
                            state_q     <= StRdHi;
                            imc_address <= hi_addr;
                        end else
`endif
                        if (req_write_q) begin
                            state_q          <= StWrLo;
                            imc_read_enable  <= 1'b0;
                            imc_write_enable <= 1'b1;
                            imc_data_in      <= wr_lo_word;
                        end else begin
                            state_q         <= StDone;
                            imc_read_enable <= 1'b0;
                            data_out        <= load_result;
                            done            <= 1'b1;
                        end
                    end
                end
`ifdef MMU_UNALIGNED_EN
                StRdHi: begin
                    if (imc_mem_ready) begin
                        hi_buf_q        <= imc_data_out;
                        imc_read_enable <= 1'b0;
                        if (req_write_q) begin
                            state_q          <= StWrLo;
                            imc_write_enable <= 1'b1;
                            imc_address      <= req_lo_q;
                            imc_data_in      <= wr_lo_word;
                        end else begin
                            state_q  <= StDone;
                            data_out <= load_result;
                            done     <= 1'b1;
                        end
                    end
                end
                StWrHi: begin
                    if (imc_mem_ready) begin
                        state_q          <= StDone;
                        imc_write_enable <= 1'b0;
                        done             <= 1'b1;
                    end
                end
`endif
                StWrLo: begin
                    if (imc_mem_ready) begin
`ifdef MMU_UNALIGNED_EN
                        if (!req_aligned_q) begin
                            state_q     <= StWrHi;
                            imc_address <= hi_addr;
                            imc_data_in <= wr_hi_word;
                        end else
`endif
                        begin
                            state_q          <= StDone;
                            imc_write_enable <= 1'b0;
                            done             <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_access_unit.sv
// Directed bench for mmu_access_unit (XLEN=32) against a two-word memory model at 0x100/0x104.
module tb_mmu_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic        signed_read;
    logic [1:0]  data_width;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] data_out;
    logic        imc_mem_ready;
    logic [31:0] imc_data_out;
    logic        imc_read_enable;
    logic        imc_write_enable;
    logic [31:0] imc_address;
    logic [31:0] imc_data_in;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem0, mem1;
    logic        mem_restore;
    logic [31:0] rd_addr [8];
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          rd_total = 0;
    int          wr_total = 0;
    int          stall_total = 0;
    int          stall_bad_total = 0;
    int          both_total = 0;
    int          stall_limit;
    logic [31:0] stall_addr;
    int          rd_base, wr_base;

    int          cyc, nrd, nwr, s0, sb0;
    logic [31:0] dout;
    logic        flt;
    bit          found;

    mmu_access_unit #(.XLEN(32), .ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .signed_read      (signed_read),
        .data_width       (data_width),
        .address          (address),
        .data_in          (data_in),
        .busy             (busy),
        .done             (done),
        .fault            (fault),
        .data_out         (data_out),
        .imc_mem_ready    (imc_mem_ready),
        .imc_data_out     (imc_data_out),
        .imc_read_enable  (imc_read_enable),
        .imc_write_enable (imc_write_enable),
        .imc_address      (imc_address),
        .imc_data_in      (imc_data_in)
    );

    always #5 clk = ~clk;

    assign imc_mem_ready = !(stall_total < stall_limit && imc_address == stall_addr);
    assign imc_data_out  = (imc_address == 32'h100) ? mem0 :
                           (imc_address == 32'h104) ? mem1 : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_restore) begin
            mem0 <= 32'h44332211;
            mem1 <= 32'h88776655;
        end else if (imc_write_enable && imc_mem_ready) begin
            if (imc_address == 32'h100) mem0 <= imc_data_in;
            else if (imc_address == 32'h104) mem1 <= imc_data_in;
        end
        if (imc_write_enable && imc_mem_ready) begin
            wr_addr[wr_total[2:0]] <= imc_address;
            wr_data[wr_total[2:0]] <= imc_data_in;
            wr_total <= wr_total + 1;
        end
        if (imc_read_enable && imc_mem_ready) begin
            rd_addr[rd_total[2:0]] <= imc_address;
            rd_total <= rd_total + 1;
        end
        if ((imc_read_enable || imc_write_enable) && !imc_mem_ready) begin
            stall_total <= stall_total + 1;
            if (imc_address != stall_addr) stall_bad_total <= stall_bad_total + 1;
        end
        if (imc_read_enable && imc_write_enable) both_total <= both_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_data_out"}, 64'(data_out), 64'd0);
        check({tag, "_imc_rd"}, 64'(imc_read_enable), 64'd0);
        check({tag, "_imc_wr"}, 64'(imc_write_enable), 64'd0);
        check({tag, "_imc_addr"}, 64'(imc_address), 64'd0);
        check({tag, "_imc_din"}, 64'(imc_data_in), 64'd0);
    endtask

    task automatic restore_mem();
        mem_restore = 1'b1;
        @(posedge clk);
        #1 mem_restore = 1'b0;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the edge following DONE.
    task automatic run(input logic we, input logic re, input logic sgn, input logic [1:0] dw,
                       input logic [31:0] addr, input logic [31:0] din, output int c,
                       output logic [31:0] d, output logic f, output int nr, output int nw);
        rd_base      = rd_total;
        wr_base      = wr_total;
        write_enable = we;
        read_enable  = re;
        signed_read  = sgn;
        data_width   = dw;
        address      = addr;
        data_in      = din;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        c = 0;
        d = '0;
        f = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                c = k;
                d = data_out;
                f = fault;
                break;
            end
            @(posedge clk);
            #1;
        end
        nr = rd_total - rd_base;
        nw = wr_total - wr_base;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        signed_read  = 1'b0;
        data_width   = 2'd0;
        address      = '0;
        data_in      = '0;
        mem_restore  = 1'b1;
        stall_addr   = 32'h100;
        stall_limit  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset       = 1'b0;
        mem_restore = 1'b0;

        run(1'b0, 1'b1, 1'b1, 2'd1, 32'h106, 32'h0, cyc, dout, flt, nrd, nwr);
        check("lh_s_data", 64'(dout), 64'hFFFF8877);
        check("lh_s_cycle", 64'(cyc), 64'd2);
        check("lh_s_nrd", 64'(nrd), 64'd1);
        check("lh_s_addr", 64'(rd_addr[rd_base % 8]), 64'h104);
        check("lh_s_fault", 64'(flt), 64'd0);

        run(1'b0, 1'b1, 1'b0, 2'd0, 32'h103, 32'h0, cyc, dout, flt, nrd, nwr);
        check("lb_u_data", 64'(dout), 64'h00000044);
        run(1'b0, 1'b1, 1'b1, 2'd0, 32'h107, 32'h0, cyc, dout, flt, nrd, nwr);
        check("lb_s_data", 64'(dout), 64'hFFFFFF88);
        run(1'b0, 1'b1, 1'b1, 2'd2, 32'h104, 32'h0, cyc, dout, flt, nrd, nwr);
        check("lw_sign_ignored", 64'(dout), 64'h88776655);

        run(1'b0, 1'b1, 1'b0, 2'd2, 32'h101, 32'h0, cyc, dout, flt, nrd, nwr);
`ifdef MMU_UNALIGNED_EN
        check("lw_ua_data", 64'(dout), 64'h55443322);
        check("lw_ua_cycle", 64'(cyc), 64'd3);
        check("lw_ua_nrd", 64'(nrd), 64'd2);
        check("lw_ua_addr0", 64'(rd_addr[rd_base % 8]), 64'h100);
        check("lw_ua_addr1", 64'(rd_addr[(rd_base + 1) % 8]), 64'h104);
`else
        check("lw_ua_fault", 64'(flt), 64'd1);
        check("lw_ua_cycle", 64'(cyc), 64'd1);
        check("lw_ua_beats", 64'(nrd + nwr), 64'd0);
        check("lw_ua_data", 64'(dout), 64'd0);
`endif

        restore_mem();
        run(1'b1, 1'b0, 1'b0, 2'd0, 32'h102, 32'hAB, cyc, dout, flt, nrd, nwr);
        check("sb_cycle", 64'(cyc), 64'd3);
        check("sb_nrd", 64'(nrd), 64'd1);
        check("sb_nwr", 64'(nwr), 64'd1);
        check("sb_wr_addr", 64'(wr_addr[wr_base % 8]), 64'h100);
        check("sb_wr_data", 64'(wr_data[wr_base % 8]), 64'h44AB2211);
        check("sb_mem1", 64'(mem1), 64'h88776655);

        restore_mem();
        run(1'b1, 1'b0, 1'b0, 2'd2, 32'h103, 32'hDEADBEEF, cyc, dout, flt, nrd, nwr);
`ifdef MMU_UNALIGNED_EN
        check("sw_ua_cycle", 64'(cyc), 64'd5);
        check("sw_ua_nwr", 64'(nwr), 64'd2);
        check("sw_ua_addr0", 64'(wr_addr[wr_base % 8]), 64'h100);
        check("sw_ua_data0", 64'(wr_data[wr_base % 8]), 64'hEF332211);
        check("sw_ua_addr1", 64'(wr_addr[(wr_base + 1) % 8]), 64'h104);
        check("sw_ua_data1", 64'(wr_data[(wr_base + 1) % 8]), 64'h88DEADBE);
`else
        check("sw_ua_fault", 64'(flt), 64'd1);
        check("sw_ua_cycle", 64'(cyc), 64'd1);
        check("sw_ua_beats", 64'(nrd + nwr), 64'd0);
        check("sw_ua_mem0", 64'(mem0), 64'h44332211);
`endif

        restore_mem();
        run(1'b1, 1'b0, 1'b0, 2'd2, 32'h104, 32'h12345678, cyc, dout, flt, nrd, nwr);
        check("sw_full_cycle", 64'(cyc), 64'd2);
        check("sw_full_nrd", 64'(nrd), 64'd0);
        check("sw_full_mem1", 64'(mem1), 64'h12345678);

        restore_mem();
        run(1'b0, 1'b1, 1'b0, 2'd3, 32'h100, 32'h0, cyc, dout, flt, nrd, nwr);
        check("ld_dw3_fault", 64'(flt), 64'd1);
        check("ld_dw3_cycle", 64'(cyc), 64'd1);
        check("ld_dw3_beats", 64'(nrd + nwr), 64'd0);
        check("ld_dw3_data", 64'(dout), 64'd0);

        // Three wait states on the only read beat.
        s0          = stall_total;
        sb0         = stall_bad_total;
        stall_addr  = 32'h100;
        stall_limit = stall_total + 3;
        run(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, cyc, dout, flt, nrd, nwr);
        check("stall_cycle", 64'(cyc), 64'd5);
        check("stall_data", 64'(dout), 64'h44332211);
        check("stall_count", 64'(stall_total - s0), 64'd3);
        check("stall_addr_held", 64'(stall_bad_total - sb0), 64'd0);
`ifdef MMU_UNALIGNED_EN
        stall_limit = stall_total + 3;
        run(1'b0, 1'b1, 1'b0, 2'd2, 32'h101, 32'h0, cyc, dout, flt, nrd, nwr);
        check("stall_ua_cycle", 64'(cyc), 64'd6);
        check("stall_ua_data", 64'(dout), 64'h55443322);
        stall_addr = 32'h104;
        address    = 32'h101;
`else
        stall_addr = 32'h100;
        address    = 32'h100;
`endif

        // Reset while a read beat is held waiting.
        stall_limit  = stall_total + 5;
        read_enable  = 1'b1;
        signed_read  = 1'b0;
        data_width   = 2'd2;
        @(posedge clk);
        #1 read_enable = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (imc_read_enable && imc_address == stall_addr) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("rst_mid_reached", 64'(found), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_mid");
        reset       = 1'b0;
        stall_limit = stall_total;
        run(1'b0, 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, cyc, dout, flt, nrd, nwr);
        check("post_rst_data", 64'(dout), 64'h44332211);
        check("post_rst_cycle", 64'(cyc), 64'd2);
        run(1'b0, 1'b1, 1'b0, 2'd0, 32'h100, 32'h0, cyc, dout, flt, nrd, nwr);
        check("b2b_data", 64'(dout), 64'h00000011);
        check("b2b_cycle", 64'(cyc), 64'd2);

        check("rd_wr_exclusive", 64'(both_total), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
